// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and serial_adder.
// SUB exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
    logic             SUB;
`endif
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             BUSY;
    logic             DONE;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output SUB,
`endif
        output START, A, B,
        input  SUM, COUT, BUSY, DONE
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  SUB,
`endif
        input  START, A, B,
        output SUM, COUT, BUSY, DONE
    );

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half adders and an OR.
// Shared by every bit position of the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1  = a ^ b;
    assign hc1  = a & b;
    assign s    = hs1 ^ cin;
    assign hc2  = hs1 & cin;
    assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder, one bit per clock, WIDTH-cycle latency.
// Define SERIAL_ADDER_SUB_EN to add the SUB (A - B) mode.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    serial_adder_if.slave bus
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             b_bit;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] s_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    assign b_bit = b_sh[0] ^ sub_q;
`else
    assign b_bit = b_sh[0];
`endif

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_bit),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // New sum bit enters at the MSB; works for WIDTH=1 too.
    assign s_next = (s_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (bus.START) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        s_sh   <= '0;
                        cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q  <= bus.SUB;
                        carry  <= bus.SUB;
`else
                        carry  <= 1'b0;
`endif
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                (state == ST_RUN): begin
                    s_sh  <= s_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_bit;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= s_next;
                        cout_q <= c_bit;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder at WIDTH 8, 1 and 13.
// Subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic CLOCK_50;
    logic RESET_N;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(8))  b8 ();
    serial_adder_if #(.WIDTH(1))  b1 ();
    serial_adder_if #(.WIDTH(13)) b13 ();

    serial_adder #(.WIDTH(8)) u_dut8 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (b8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (b1)
    );

    serial_adder #(.WIDTH(13)) u_dut13 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (b13)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input int w, input logic [31:0] a, b,
                         input logic sb, output logic [31:0] s,
                         output logic c);
        longint unsigned m;
        longint unsigned av;
        longint unsigned bv;
        longint unsigned r;
        m  = (64'd1 << w) - 64'd1;
        av = {32'd0, a} & m;
        bv = {32'd0, b} & m;
        if (sb) begin
            r = (av - bv) & m;
            s = r[31:0];
            c = (av >= bv);
        end else begin
            r = av + bv;
            s = 32'(r & m);
            c = ((r >> w) & 64'd1) != 64'd0;
        end
    endtask

    task automatic drive(input int w, input logic st,
                         input logic [31:0] a, b, input logic sb);
        case (w)
            1: begin
                b1.START = st;
                b1.A = a[0];
                b1.B = b[0];
`ifdef SERIAL_ADDER_SUB_EN
                b1.SUB = sb;
`endif
            end
            13: begin
                b13.START = st;
                b13.A = a[12:0];
                b13.B = b[12:0];
`ifdef SERIAL_ADDER_SUB_EN
                b13.SUB = sb;
`endif
            end
            default: begin
                b8.START = st;
                b8.A = a[7:0];
                b8.B = b[7:0];
`ifdef SERIAL_ADDER_SUB_EN
                b8.SUB = sb;
`endif
            end
        endcase
    endtask

    task automatic sample(input int w, output logic [31:0] sum,
                          output logic cout, busy, done);
        case (w)
            1: begin
                sum = 32'(b1.SUM);
                cout = b1.COUT;
                busy = b1.BUSY;
                done = b1.DONE;
            end
            13: begin
                sum = 32'(b13.SUM);
                cout = b13.COUT;
                busy = b13.BUSY;
                done = b13.DONE;
            end
            default: begin
                sum = 32'(b8.SUM);
                cout = b8.COUT;
                busy = b8.BUSY;
                done = b8.DONE;
            end
        endcase
    endtask

    task automatic check_zero(input int w, input string tag);
        logic [31:0] s;
        logic c, bz, d;
        sample(w, s, c, bz, d);
        check($sformatf("%s_w%0d_sum", tag, w), s, 32'd0);
        check($sformatf("%s_w%0d_cout", tag, w), 32'(c), 32'd0);
        check($sformatf("%s_w%0d_busy", tag, w), 32'(bz), 32'd0);
        check($sformatf("%s_w%0d_done", tag, w), 32'(d), 32'd0);
    endtask

    // sync=0 drives START in the current cycle (used for the DONE cycle);
    // noise=1 keeps START high with 0x11/0x22 while the op is running.
    task automatic do_op(input int w, input logic [31:0] a, b,
                         input logic sb, input bit sync, input bit noise,
                         input string tag);
        logic [31:0] es, s;
        logic ec, c, bz, d;
        int cyc;
        model(w, a, b, sb, es, ec);
        if (sync) @(negedge CLOCK_50);
        drive(w, 1'b1, a, b, sb);
        @(posedge CLOCK_50);
        #1;
        drive(w, noise, 32'h11, 32'h22, $urandom_range(0, 1) != 0);
        sample(w, s, c, bz, d);
        check($sformatf("%s_busy0", tag), 32'(bz), 32'd1);
        cyc = 0;
        while (!d && cyc < w + 4) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            sample(w, s, c, bz, d);
            if (d) drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
            else if (cyc < w) check($sformatf("%s_busy", tag), 32'(bz), 32'd1);
        end
        check($sformatf("%s_lat", tag), cyc, w);
        check($sformatf("%s_busy_done", tag), 32'(bz), 32'd0);
        check($sformatf("%s_sum", tag), s, es);
        check($sformatf("%s_cout", tag), 32'(c), 32'(ec));
    endtask

    initial begin
        logic [31:0] s, es;
        logic c, ec, bz, d;
        logic [31:0] ra, rb;
        logic rs;
        int ndone;
        checks = 0;
        errors = 0;
        RESET_N = 1'b0;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        drive(13, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_zero(8, "rst");
        check_zero(1, "rst");
        check_zero(13, "rst");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        do_op(8, 32'h5A, 32'h3C, 1'b0, 1, 0, "a5a_3c");
        @(posedge CLOCK_50);
        #1;
        sample(8, s, c, bz, d);
        check("hold_done", 32'(d), 32'd0);
        check("hold_sum", s, 32'h96);
        do_op(8, 32'hFF, 32'h01, 1'b0, 1, 0, "aff_01");
        do_op(8, 32'h00, 32'h00, 1'b0, 1, 0, "a00_00");

        do_op(8, 32'hA7, 32'h6C, 1'b0, 1, 1, "ignored");
        do_op(8, 32'h11, 32'h22, 1'b0, 0, 0, "b2b");

        @(negedge CLOCK_50);
        drive(8, 1'b1, 32'hC3, 32'h5F, 1'b0);
        @(posedge CLOCK_50);
        #1;
        drive(8, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b0;
        #1;
        check_zero(8, "midrst");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(posedge CLOCK_50);
            #1;
            sample(8, s, c, bz, d);
            if (d) ndone++;
        end
        check("midrst_nodone", ndone, 0);
        do_op(8, 32'h5A, 32'h3C, 1'b0, 1, 0, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8, 32'h10, 32'h01, 1'b1, 1, 0, "sub10_01");
        do_op(8, 32'h01, 32'h02, 1'b1, 1, 0, "sub01_02");
`endif

        do_op(1, 32'h1, 32'h1, 1'b0, 1, 0, "w1_11");
        for (int i = 0; i < 4; i++) begin
            do_op(1, i & 1, i >> 1, 1'b0, 1, 0, $sformatf("w1_%0d", i));
        end

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef SERIAL_ADDER_SUB_EN
            rs = $urandom_range(0, 1) != 0;
`else
            rs = 1'b0;
`endif
            do_op(13, ra, rb, rs, $urandom_range(0, 1) != 0, 0,
                  $sformatf("r13_%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(8, ra, rb, 1'b0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, $sformatf("r8_%0d", i));
        end

        model(8, 32'h5A, 32'h3C, 1'b0, es, ec);
        check("model_5a3c", es, 32'h96);
        check("model_5a3c_c", 32'(ec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder that extends the gate-level half-adder into a clocked, multi-bit datapath. It accepts two WIDTH-bit operands with a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It returns a WIDTH-bit sum, a carry-out and a one-cycle completion strobe. It sits between board switch/key inputs and LED/display outputs on the DE2 designs, and is reusable wherever area matters more than latency.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1..32.
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only while BUSY is low.
- A  input  WIDTH  operand A; captured on an accepted START.
- B  input  WIDTH  operand B; captured on an accepted START.
- SUB  input  1  0 = add, 1 = subtract (A − B); present only when SERIAL_ADDER_SUB_EN is defined.
- SUM  output  WIDTH  result; held stable from DONE until the next accepted START.
- COUT  output  1  final carry; for subtraction, 1 = no borrow.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when SUM/COUT become valid.

## Operation
- States: IDLE and RUN. The state is a 1-bit register; there is also a bit counter of width $clog2(WIDTH+1).
- IDLE: BUSY=0. On START=1, the block:
  - loads A and B into shift registers,
  - clears the carry flip-flop (or sets it to SUB when the macro is enabled),
  - clears the counter and the sum shift register,
  - moves to RUN.
- RUN: BUSY=1. Each cycle, the full-adder cell takes the A and B register LSBs (B inverted when SUB) plus the carry flip-flop.
  - The sum bit shifts into the sum register MSB.
  - The operand registers shift right by 1.
  - The carry flip-flop takes the cell carry.
  - The counter increments.
- When the counter reaches WIDTH−1 in RUN, at that edge the block:
  - writes the final shifted sum to SUM and the cell carry to COUT,
  - sets DONE=1,
  - returns to IDLE.
- START while BUSY=1 is ignored. A, B and SUB are don't-care outside the accept cycle.
- SUM and COUT update only on completion; intermediate shifting is never visible on the outputs.
- Arithmetic: result = A + B (+ carry-in) modulo 2^WIDTH. COUT is bit WIDTH of the exact sum. No signed-overflow flag is produced.
- Reset (RESET_N=0, any time, including mid-RUN) sets state=IDLE, counter=0, shift registers=0, SUM=0, COUT=0, BUSY=0, DONE=0. A partial operation is discarded, with no DONE pulse.

## Timing
- START accepted at edge n. BUSY is high from n until edge n+WIDTH. DONE, SUM and COUT are valid after edge n+WIDTH. Latency is WIDTH cycles.
- DONE is high for exactly one cycle, and BUSY is low in that same cycle. A START present in the DONE cycle is accepted, so back-to-back operations run with zero idle cycles. Throughput is one result per WIDTH cycles.
- WIDTH=1: RUN lasts one cycle, and DONE follows 1 cycle after START.
- Reset deassertion is asynchronous to the clock. The first START is honoured at the first rising edge with RESET_N high.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the SUB port exists,
  - B is inverted on entry to the cell,
  - the initial carry equals SUB, which gives two's-complement subtraction.
- Not defined:
  - no SUB port,
  - the initial carry is 0,
  - the block is an adder only.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding constants (ST_IDLE=1'b0, ST_RUN=1'b1),
  - the counter-width function/constant,
  - the default WIDTH.
- One sub-module, full_adder_cell (inputs a, b, cin; outputs s, cout), built from two half-adder gate pairs plus an OR. The top level instantiates it once.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, START at edge n → BUSY for 8 cycles; at edge n+8, SUM=0x96, COUT=0, DONE pulse of 1 cycle.
- WIDTH=8, A=0xFF, B=0x01 → SUM=0x00, COUT=1; A=0x00, B=0x00 → SUM=0x00, COUT=0.
- START re-asserted with A=0x11, B=0x22 during RUN → ignored; the first result is delivered unchanged. A START in the DONE cycle with A=0x11, B=0x22 → SUM=0x33 eight cycles later.
- RESET_N pulsed low at cycle 4 of RUN → all outputs 0 immediately, no DONE; the next START completes normally.
- With SERIAL_ADDER_SUB_EN: SUB=1, A=0x10, B=0x01 → SUM=0x0F, COUT=1; SUB=1, A=0x01, B=0x02 → SUM=0xFF, COUT=0.
- WIDTH=1: A=1, B=1 → SUM=0, COUT=1, DONE one cycle after START; random compare against A+B over 1000 operations at WIDTH=13.
